// File: rtl/cnn_pkg.sv
// Shared constants, pixel types and small arithmetic helpers for the pooling stage.
// POOL_AVG_EN widens the accumulator type so that partial sums can be held.
package cnn_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int ConvOut    = 28;
  localparam int DepthC     = 6;
  localparam int PoolOut    = ConvOut / 2;

  localparam int COL_W  = $clog2(ConvOut);
  localparam int CHAN_W = $clog2(DepthC);
  localparam int IDX_W  = $clog2(PoolOut);

  typedef logic signed [DATA_WIDTH-1:0] pixel_t;

`ifdef POOL_AVG_EN
  typedef logic signed [DATA_WIDTH:0] acc_t;

  function automatic acc_t to_acc(input pixel_t p);
    return {p[DATA_WIDTH-1], p};
  endfunction
`else
  typedef pixel_t acc_t;

  function automatic acc_t to_acc(input pixel_t p);
    return p;
  endfunction
`endif

  function automatic pixel_t smax(input pixel_t a, input pixel_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic pixel_t relu(input pixel_t v);
    return v[DATA_WIDTH-1] ? '0 : v;
  endfunction
endpackage

// File: rtl/pool_linebuf.sv
// Row buffer of horizontal pair results: written on even input rows, read on odd rows.
// Combinational read, one write per cycle; contents need no reset.
module pool_linebuf
  import cnn_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
)(
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [PoolOut];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/conv_pool_relu_stream.sv
// 2x2 stride-2 pooling (max; average when POOL_AVG_EN is defined) then ReLU on a raster pixel stream.
// Output registered 1 cycle after a window's 4th pixel; single output slot, in_ready drops only while it stalls.
module conv_pool_relu_stream
  import cnn_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  frame_done
);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(ConvOut - 1);
  localparam logic [CHAN_W-1:0] CHAN_LAST = CHAN_W'(DepthC - 1);

  logic [COL_W-1:0]  r_col;
  logic [COL_W-1:0]  r_row;
  logic [CHAN_W-1:0] r_chan;
  acc_t              r_pair;
  logic              r_out_vld;
  pixel_t            r_out_dat;
  logic              r_out_last;

  logic              w_accept;
  logic              w_lb_we;
  logic              w_win_done;
  logic              w_frame_last;
  logic [IDX_W-1:0]  w_idx;
  pixel_t            w_pix;
  pixel_t            w_win;
  acc_t              w_hval;
  acc_t              w_lb_rdat;

  assign w_pix        = pixel_t'(in_data);
  assign in_ready     = !r_out_vld || out_ready;
  assign w_accept     = in_valid && in_ready;
  assign w_idx        = IDX_W'(r_col >> 1);
  assign w_lb_we      = w_accept && !r_row[0] && r_col[0];
  assign w_win_done   = w_accept && r_row[0] && r_col[0];
  assign w_frame_last = (r_chan == CHAN_LAST) && (r_row == COL_LAST) && (r_col == COL_LAST);

`ifdef POOL_AVG_EN
  logic signed [DATA_WIDTH+1:0] w_sum4;

  assign w_hval = r_pair + to_acc(w_pix);
  assign w_sum4 = {w_lb_rdat[DATA_WIDTH], w_lb_rdat} + {w_hval[DATA_WIDTH], w_hval};
  // Arithmetic shift floors toward minus infinity; the quotient always fits a pixel.
  assign w_win  = pixel_t'(w_sum4 >>> 2);
`else
  assign w_hval = smax(r_pair, w_pix);
  assign w_win  = smax(w_lb_rdat, w_hval);
`endif

  pool_linebuf #(
    .WIDTH ($bits(acc_t))
  ) u_linebuf (
    .i_clk   (clk),
    .i_we    (w_lb_we),
    .i_waddr (w_idx),
    .i_wdata (w_hval),
    .i_raddr (w_idx),
    .o_rdata (w_lb_rdat)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col  <= '0;
      r_row  <= '0;
      r_chan <= '0;
      r_pair <= '0;
    end else if (w_accept) begin
      if (r_col == COL_LAST) begin
        r_col <= '0;
        if (r_row == COL_LAST) begin
          r_row  <= '0;
          r_chan <= (r_chan == CHAN_LAST) ? '0 : r_chan + CHAN_W'(1);
        end else begin
          r_row <= r_row + COL_W'(1);
        end
      end else begin
        r_col <= r_col + COL_W'(1);
      end
      if (!r_col[0]) r_pair <= to_acc(w_pix);
    end
  end

  // A completing window can only be accepted when the slot is empty or draining, so no result is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_vld  <= 1'b0;
      r_out_dat  <= '0;
      r_out_last <= 1'b0;
    end else if (w_win_done) begin
      r_out_vld  <= 1'b1;
      r_out_dat  <= relu(w_win);
      r_out_last <= w_frame_last;
    end else if (out_ready) begin
      r_out_vld <= 1'b0;
    end
  end

  assign out_valid  = r_out_vld;
  assign out_data   = r_out_dat;
  assign frame_done = r_out_vld && out_ready && r_out_last;
endmodule

// File: tb/tb_conv_pool_relu_stream.sv
// Randomised stream bench for conv_pool_relu_stream against a window-level pooling model.
module tb_conv_pool_relu_stream;
  import cnn_pkg::*;

  localparam int CH_PIX = ConvOut * ConvOut;
  localparam int NPIX   = DepthC * CH_PIX;
  localparam int NOUT   = DepthC * PoolOut * PoolOut;
  localparam int BUDGET = 40000;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  frame_done;

  int errors = 0;
  int checks = 0;

  int                    frm [DepthC][ConvOut][ConvOut];
  logic [DATA_WIDTH-1:0] exp_q[$];
  bit                    last_q[$];
  logic [DATA_WIDTH-1:0] got_q[$];
  logic [DATA_WIDTH-1:0] ramp_got[$];
  int                    in_idx;
  int                    done_cnt;
  int                    run_cycles;
  bit                    exp_vld;

  conv_pool_relu_stream dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pix_at(input int idx);
    return frm[idx / CH_PIX][(idx % CH_PIX) / ConvOut][idx % ConvOut];
  endfunction

  // kind 0: ramp, 1: constant -256, 2: random with special windows at the start of channel 0
  task automatic fill_frame(input int kind);
    logic signed [DATA_WIDTH-1:0] s;
    for (int c = 0; c < DepthC; c++)
      for (int r = 0; r < ConvOut; r++)
        for (int k = 0; k < ConvOut; k++) begin
          s = DATA_WIDTH'($urandom);
          if (kind == 0)      frm[c][r][k] = r * ConvOut + k + c * 1000;
          else if (kind == 1) frm[c][r][k] = -256;
          else                frm[c][r][k] = s;
        end
    if (kind == 2) begin
`ifdef POOL_AVG_EN
      frm[0][0][0] = 4;  frm[0][0][1] = 8;  frm[0][1][0] = 12; frm[0][1][1] = 16;
      frm[0][0][2] = -4; frm[0][0][3] = -4; frm[0][1][2] = -4; frm[0][1][3] = -3;
`else
      frm[0][0][0] = -32768; frm[0][0][1] = 32767; frm[0][1][0] = 5; frm[0][1][1] = -3;
      for (int r = 0; r < 2; r++)
        for (int k = 2; k < 4; k++) frm[0][r][k] = -32768;
`endif
    end
  endtask

  task automatic build_expected();
    int a, b, c2, d, w;
    exp_q.delete();
    last_q.delete();
    for (int c = 0; c < DepthC; c++)
      for (int pr = 0; pr < PoolOut; pr++)
        for (int pc = 0; pc < PoolOut; pc++) begin
          a  = frm[c][2*pr][2*pc];
          b  = frm[c][2*pr][2*pc+1];
          c2 = frm[c][2*pr+1][2*pc];
          d  = frm[c][2*pr+1][2*pc+1];
`ifdef POOL_AVG_EN
          w = (a + b + c2 + d) >>> 2;
`else
          w = a;
          if (b > w)  w = b;
          if (c2 > w) w = c2;
          if (d > w)  w = d;
`endif
          if (w < 0) w = 0;
          exp_q.push_back(DATA_WIDTH'(w));
          last_q.push_back(c == DepthC-1 && pr == PoolOut-1 && pc == PoolOut-1);
        end
  endtask

  // rmode 0: always ready, 1: ready 1 cycle in 3, 2: random. vmode 0: always valid, 1: random.
  task automatic run(input int n_in, input int rmode, input int vmode, input bit partial);
    int cyc = 0;
    bit stalled = 1'b0;
    bit comp;
    logic [DATA_WIDTH-1:0] held = '0;
    logic [DATA_WIDTH-1:0] e;
    bit el;
    got_q.delete();
    done_cnt = 0;
    while (1) begin
      if (in_idx == n_in && (partial || exp_q.size() == 0)) break;
      if (cyc >= BUDGET) begin
        chk("timeout_inputs", in_idx, n_in);
        break;
      end
      @(negedge clk);
      in_valid  = (in_idx < n_in) && (vmode == 0 || $urandom_range(0, 3) != 0);
      in_data   = in_valid ? DATA_WIDTH'(pix_at(in_idx)) : DATA_WIDTH'($urandom);
      out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      #1;
      chk("out_valid", out_valid, exp_vld);
      chk("in_ready", in_ready, !exp_vld || out_ready);
      if (stalled) chk("hold_data", out_data, held);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", out_valid, 0);
        end else begin
          e  = exp_q.pop_front();
          el = last_q.pop_front();
          chk("out_data", out_data, e);
          chk("frame_done", frame_done, el);
          got_q.push_back(out_data);
        end
      end else begin
        chk("frame_done_idle", frame_done, 0);
      end
      if (frame_done === 1'b1) done_cnt++;
      stalled = out_valid && !out_ready;
      held    = out_data;
      comp    = 1'b0;
      if (in_valid && in_ready) begin
        comp = ((in_idx % CH_PIX) / ConvOut) % 2 == 1 && (in_idx % ConvOut) % 2 == 1;
        in_idx++;
      end
      exp_vld = comp || (exp_vld && !out_ready);
      cyc++;
    end
    run_cycles = cyc;
  endtask

  initial begin
    int mism;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    exp_vld   = 1'b0;
    in_idx    = 0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b0;

    // Ramp frame at full throughput
    fill_frame(0);
    build_expected();
    in_idx = 0;
    run(NPIX, 0, 0, 1'b0);
    chk("ramp_count", got_q.size(), NOUT);
    chk("ramp_frame_done", done_cnt, 1);
    chk("ramp_cycles", run_cycles, NPIX + 1);
`ifndef POOL_AVG_EN
    chk("ramp_out_0_0", got_q[0], 29);
    chk("ramp_out_13_13", got_q[PoolOut*PoolOut-1], 783);
`endif
    ramp_got = got_q;
    @(negedge clk);
    #1 chk("idle_after_frame", out_valid, 0);

    // All-negative frame
    fill_frame(1);
    build_expected();
    in_idx = 0;
    run(NPIX, 0, 1, 1'b0);
    chk("neg_count", got_q.size(), NOUT);
    chk("neg_frame_done", done_cnt, 1);

    // Ramp again with 1-in-3 output backpressure
    fill_frame(0);
    build_expected();
    in_idx = 0;
    run(NPIX, 1, 0, 1'b0);
    chk("bp_len", got_q.size(), ramp_got.size());
    mism = 0;
    for (int i = 0; i < got_q.size() && i < ramp_got.size(); i++)
      if (got_q[i] !== ramp_got[i]) mism++;
    chk("bp_seq_diffs", mism, 0);
    chk("bp_frame_done", done_cnt, 1);

    // Random data and handshakes, extreme-value windows first
    fill_frame(2);
    build_expected();
    in_idx = 0;
    run(NPIX, 2, 1, 1'b0);
    chk("rand_frame_done", done_cnt, 1);
`ifdef POOL_AVG_EN
    chk("avg_4_8_12_16", got_q[0], 10);
    chk("avg_neg_floor", got_q[1], 0);
`else
    chk("max_extremes", got_q[0], 16'h7FFF);
    chk("max_all_min", got_q[1], 0);
`endif

    // Reset mid-row 7 of channel 2 with a result pending
    fill_frame(2);
    build_expected();
    in_idx = 0;
    run(2*CH_PIX + 7*ConvOut + 14, 2, 1, 1'b1);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1 chk("pre_reset_pending", out_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_frame_done", frame_done, 0);
    repeat (2) @(negedge clk);
    reset   = 1'b0;
    exp_vld = 1'b0;
    fill_frame(2);
    build_expected();
    in_idx = 0;
    run(NPIX, 2, 1, 1'b0);
    chk("fresh_count", got_q.size(), NOUT);
    chk("fresh_frame_done", done_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/conv_pool_relu_stream.md
Name: conv_pool_relu_stream

Overview:
- Streaming stage directly downstream of the multi-channel convolution layer (C1).
- Consumes convolution outputs one pixel per handshake: raster order within a channel, channels sequential.
- Applies 2x2 stride-2 max pooling followed by ReLU.
- Emits pooled pixels (14x14 per channel at defaults) in raster order, feeding the next convolution/subsampling stage.

Parameters:
- DATA_WIDTH, 16, pixel width; signed two's-complement fixed point.
- ConvOut, 28, input feature-map width and height; must be even.
- DepthC, 6, number of channels per frame.
- PoolOut, ConvOut/2, output map width and height; derived, not overridable.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-high reset.
- in_valid, input, 1, in_data is valid.
- in_ready, output, 1, block accepts in_data this cycle.
- in_data, input, DATA_WIDTH, convolution output pixel, signed.
- out_valid, output, 1, out_data is valid.
- out_ready, input, 1, downstream accepts out_data.
- out_data, output, DATA_WIDTH, pooled and ReLU'd pixel, signed, never negative.
- frame_done, output, 1, one-cycle pulse with acceptance of the last output of channel DepthC-1.

Behaviour:
- Reset (async, active-high):
  - out_valid=0, out_data=0, frame_done=0.
  - col/row/chan counters=0; pair register cleared.
  - Line buffer contents are don't-care; every entry is written on an even row before it is read.
- in_ready = !out_valid || out_ready, combinational.
- Input accept: in_valid && in_ready. Counters advance only on accept.
  - col wraps at ConvOut-1, then row increments.
  - row wraps at ConvOut-1, then chan increments.
  - chan wraps at DepthC-1 back to 0.
- Horizontal pair:
  - Even col: latch pixel into pair register.
  - Odd col: hmax = signed max(pair register, pixel).
- Vertical combine:
  - Even row, odd col: write hmax to linebuf[col>>1].
  - Odd row, odd col: window = signed max(linebuf[col>>1], hmax). Register max(window,0) into out_data and set out_valid.
- Latency: out_valid asserts the cycle after the 4th pixel of a window (bottom-right) is accepted.
- Output register:
  - Holds out_data stable while out_valid && !out_ready.
  - Clears out_valid on out_ready unless a new window completes in the same cycle, in which case it reloads back-to-back.
- Backpressure: at most one output pending; no input loss; full throughput when out_ready stays high.
- frame_done: asserted in the cycle the output for chan=DepthC-1, row=ConvOut-1, col=ConvOut-1 is consumed (out_valid && out_ready). The next frame starts at chan 0 with no gap.
- Signed compare throughout. Equal values: either operand (identical result).
- Most negative input (0x8000) yields 0 after ReLU.
- Reset mid-frame: all state discarded; the next accepted pixel is (chan 0, row 0, col 0).

Optional Feature:
- POOL_AVG_EN defined: average pooling replaces max.
  - pair/linebuf hold DATA_WIDTH+1-bit sums.
  - window = (sum of 4, DATA_WIDTH+2 bits) arithmetic-shifted right by 2, truncating toward minus infinity.
  - ReLU is still applied afterwards.
- POOL_AVG_EN undefined: max pooling as above.
- Handshake and latency are identical in both modes.

Decomposition:
- Shared package cnn_pkg: DATA_WIDTH, ConvOut, DepthC, PoolOut constants; pixel_t signed typedef; counter widths ($clog2 of ConvOut, DepthC).
- One sub-module, pool_linebuf: PoolOut-entry, single-write/single-read register array, write on even rows and read on odd rows by index col>>1.

Test Plan:
1. Ramp frame: pixel = row*28+col, channel 0, out_ready=1. Expected: out(0,0)=29, out(13,13)=783; 196 outputs per channel.
2. All-negative frame: every input 0xFF00 (-256). Expected: every output 0; frame_done pulses once after 1176 outputs.
3. Backpressure: toggle out_ready 1-of-3 cycles. Expected: out_data stable while stalled; output sequence identical to test 1; in_ready low only while out_valid && !out_ready.
4. Window with 0x8000, 0x7FFF, 5, -3. Expected: out 0x7FFF. Window of all 0x8000: expected out 0.
5. Reset asserted mid-row 7 of channel 2, then a fresh frame. Expected: out_valid=0 immediately; first output equals the fresh frame's (0,0) window; no stale line-buffer data.
6. POOL_AVG_EN build: window 4, 8, 12, 16: expected out 10. Window -4, -4, -4, -3: expected out 0.
